// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage and its buffers.
package if_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Redirect targets are truncated to a word boundary; execute owns misalignment traps.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_checkers.sv
// Property checkers for the fetch FIFO and the fetch stage credit bookkeeping.
module fetch_fifo_chk (
    input logic clk_i,
    input logic rst_i,
    input logic flush_i,
    input logic push_i,
    input logic pop_i,
    input logic full_i,
    input logic empty_i
);

    push_on_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && full_i && !pop_i && !flush_i));

    pop_on_empty_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop_i && empty_i && !flush_i));

endmodule

module fetch_stage_chk #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = 2
) (
    input logic          clk_i,
    input logic          rst_i,
    input logic [CW-1:0] outstanding_i,
    input logic [CW-1:0] discard_i,
    input logic [CW-1:0] shadow_count_i,
    input logic [CW-1:0] buf_count_i,
    input logic          buf_full_i,
    input logic          shadow_full_i
);

    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    // Every outstanding read is either tracked by the shadow queue or marked for discard.
    shadow_tracks_a: assert property (@(posedge clk_i) disable iff (rst_i)
        ({1'b0, outstanding_i} == {1'b0, shadow_count_i} + {1'b0, discard_i}));

    credit_bound_a: assert property (@(posedge clk_i) disable iff (rst_i)
        ({1'b0, buf_count_i} + {1'b0, outstanding_i} <= DEPTH_C));

    full_buf_idle_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (buf_full_i |-> (outstanding_i == '0)));

    full_shadow_empty_buf_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (shadow_full_i |-> (buf_count_i == '0)));

endmodule

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; simultaneous push and pop is accepted even when full.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type T = logic [31:0],
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  T              data_i,
    input  logic          pop_i,
    output T              data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == DEPTH_C);
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Pointer and occupancy next state; flush wins over any push or pop.
    always_comb begin
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
            wr_ptr_d = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
            count_d  = count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push_s && !flush_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    fetch_fifo_chk u_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push_i),
        .pop_i   (pop_i),
        .full_i  (full_o),
        .empty_i (empty_o)
    );

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited word reads and buffers {pc, instr}.
module fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instr_o
);

    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] outstanding_d;
    logic [CW-1:0] discard_q;
    logic [CW-1:0] discard_d;

    fetch_entry_t  buf_in_s;
    fetch_entry_t  buf_head_s;
    logic [CW-1:0] buf_count_s;
    logic          buf_full_s;
    logic          buf_empty_s;
    logic [31:0]   shadow_pc_s;
    logic [CW-1:0] shadow_count_s;
    logic          shadow_full_s;
    logic          shadow_empty_s;

    logic [CW:0]   credit_used_s;
    logic          issue_s;
    logic          accept_rsp_s;
    logic          buf_pop_s;

    // Buffered entries plus reads in flight (including ones to be discarded) share one credit pool.
    assign credit_used_s = {1'b0, buf_count_s} + {1'b0, outstanding_q};
    assign issue_s       = !rst_i && !redirect_i && (credit_used_s < DEPTH_C);
    assign accept_rsp_s  = imem_rvalid_i && !redirect_i && (discard_q == '0);
    assign buf_pop_s     = !buf_empty_s && ready_i && !redirect_i;
    assign buf_in_s      = '{pc: shadow_pc_s, instr: imem_rdata_i};

    assign imem_req_o  = issue_s;
    assign imem_addr_o = pc_q;
    assign valid_o     = !buf_empty_s;
    assign pc_o        = buf_empty_s ? pc_q : buf_head_s.pc;
    assign pc_plus4_o  = pc_o + 32'd4;
    assign instr_o     = buf_empty_s ? NOP_INSTR : buf_head_s.instr;

    // PC, in-flight and discard counter next state; redirect overrides sequential fetch.
    always_comb begin
        if (redirect_i) begin
            pc_d = word_align(redirect_pc_i);
        end else if (issue_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end

        outstanding_d = outstanding_q + CW'(issue_s) - CW'(imem_rvalid_i);

        if (redirect_i) begin
            discard_d = outstanding_q - CW'(imem_rvalid_i);
        end else if (imem_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end else begin
            discard_d = discard_q;
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_entry_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (accept_rsp_s),
        .data_i  (buf_in_s),
        .pop_i   (buf_pop_s),
        .data_o  (buf_head_s),
        .count_o (buf_count_s),
        .full_o  (buf_full_s),
        .empty_o (buf_empty_s)
    );

    // Issued addresses in order, so each accepted response is tagged with its own PC.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (logic [31:0])
    ) u_pc_shadow (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (issue_s),
        .data_i  (pc_q),
        .pop_i   (accept_rsp_s),
        .data_o  (shadow_pc_s),
        .count_o (shadow_count_s),
        .full_o  (shadow_full_s),
        .empty_o (shadow_empty_s)
    );

    fetch_stage_chk #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk_i          (clk_i),
        .rst_i          (rst_i || shadow_empty_s && 1'b0),
        .outstanding_i  (outstanding_q),
        .discard_i      (discard_q),
        .shadow_count_i (shadow_count_s),
        .buf_count_i    (buf_count_s),
        .buf_full_i     (buf_full_s),
        .shadow_full_i  (shadow_full_s)
    );

endmodule
